stream_credit_tx: RTL



---
 rtl/stream_credit_tx.sv | 61 ++++++
 1 files changed

// File: rtl/stream_credit_tx.sv
// stream_credit_tx: transmit end of a credit-based link with a registered beat output
module stream_credit_tx #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CREDITS = 4,
    parameter int CNT_WIDTH   = $clog2(NUM_CREDITS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  credit_i,
    output logic [CNT_WIDTH-1:0]  credit_cnt_o,
    output logic                  idle_o,
    output logic                  err_o
);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(NUM_CREDITS);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_err;
    logic                  w_send;
    logic                  w_ovf;
    assign ready_o      = r_cnt != '0;
    assign valid_o      = r_valid;
    assign data_o       = r_data;
    assign credit_cnt_o = r_cnt;
    assign err_o        = r_err;
    assign idle_o       = (r_cnt == MAX_CNT) && !r_valid;
    // send/credit arbitration; a credit arriving on a full counter with no send is an overflow and saturates
    always_comb begin
        w_send    = valid_i && ready_o;
        w_ovf     = credit_i && !w_send && (r_cnt == MAX_CNT);
        w_cnt_nxt = (w_send && !credit_i) ? r_cnt - ONE :
                    (credit_i && !w_send && !w_ovf) ? r_cnt + ONE : r_cnt;
    end
    // state registers; clr_i acts like reset and overrides any send or credit in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= MAX_CNT;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (clr_i) begin
            r_cnt   <= MAX_CNT;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_send;
            if (w_send) r_data <= data_i;
            if (w_ovf) r_err <= 1'b1;
        end
    end
endmodule
